// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises one byte per request into an
// asynchronous frame: start bit, DBIT data bits LSB first, optional parity
// bit, then the stop period. Each bit is 16 s_tick strobes wide. The stop
// period is SB_TICK strobes wide. The block never counts raw clocks.
//
// Optional feature: define UART_TX_PARITY_EN to add a parity bit after the
// data bits. The parity bit is even parity over din[DBIT-1:0]. It is inverted
// when parity_odd is 1. Both din and parity_odd are sampled when the request
// is accepted.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   tx_start     one-cycle send request, honoured only in IDLE
//   s_tick       16x baud strobe from the baud counter
//   din          byte to send; bits [DBIT-1:0] are used
//   parity_odd   (UART_TX_PARITY_EN only) invert the parity bit
//   tx_busy      high while a frame is in progress
//   tx_done_tick one-cycle pulse when the frame completes
//   tx           registered serial line, idles high
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic       s_tick,
    input  logic [7:0] din,
`ifdef UART_TX_PARITY_EN
    input  logic       parity_odd,
`endif
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);
    // The tick counter must reach SB_TICK-1 in the stop state.
    localparam int SW = (SB_TICK > 16) ? 5 : 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [2:0]      n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            tx_reg, tx_next;
    logic            done_next;
`ifdef UART_TX_PARITY_EN
    logic            p, p_next;
`endif

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        p_next     = p;
`endif
        case (state)
            IDLE: begin
                if (tx_start) begin
                    b_next     = din[DBIT-1:0];
                    s_next     = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    p_next     = (^din[DBIT-1:0]) ^ parity_odd;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_next = '0;
                        b_next = b >> 1;
                        if (n == 3'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The pin level is derived from the next state so that it can be
    // registered. As a result tx changes on the same edge as the state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = p_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx_reg       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
            p            <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            tx_reg       <= tx_next;
            tx_busy      <= (state_next != IDLE);
            tx_done_tick <= done_next;
`ifdef UART_TX_PARITY_EN
            p            <= p_next;
`endif
        end
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (DBIT=8, SB_TICK=16).
// s_tick fires every 4 clocks. The line is sampled on each s_tick, which gives
// exactly 16 samples per bit.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_TICKS = 176;
`else
    localparam int FRAME_TICKS = 160;
`endif

    logic       clk, reset, tx_start, s_tick, tick_en;
    logic [7:0] din;
    logic       tx_busy, tx_done_tick, tx;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd;
`endif

    int checks = 0, errors = 0;
    logic samp [0:511];
    int done_at, fall_at, last_tick_at, busy_clks, done_cnt;

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
        .din(din),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int ph;
        ph = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph == 3) ? 0 : ph + 1;
            s_tick = tick_en && (ph == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(posedge clk); #1;
        din = d; tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    // Record tx on each of the next nticks s_tick cycles. Keep watching for
    // three more clocks so that tx_done_tick and the idle line are seen.
    task automatic capture(input int nticks);
        int k, ci;
        k = 0; ci = 0;
        done_at = -1; fall_at = -1; last_tick_at = 1 << 30;
        busy_clks = 0; done_cnt = 0;
        while (ci < nticks * 4 + 200 && (k < nticks || ci < last_tick_at + 3)) begin
            @(negedge clk);
            ci++;
            if (tx_busy) busy_clks++;
            if (tx_done_tick) begin
                done_cnt++;
                if (done_at < 0) done_at = ci;
            end
            if (done_at >= 0 && fall_at < 0 && ci > done_at && tx === 1'b0) fall_at = ci;
            if (s_tick && k < nticks) begin
                samp[k] = tx;
                k++;
                if (k == nticks) last_tick_at = ci;
            end
        end
        if (k < nticks) chk("capture_timeout", 32'(k), 32'(nticks));
    endtask

    task automatic check_frame(input string tag, input int off, input logic [7:0] exp);
        logic [7:0] got;
        int bad, sp;
        bad = 0; got = '0; sp = off + 144;
        for (int i = 0; i < 16; i++) if (samp[off + i] !== 1'b0) bad++;
        for (int j = 0; j < 8; j++) begin
            got[j] = samp[off + 16 + 16 * j];
            for (int i = 0; i < 16; i++)
                if (samp[off + 16 + 16 * j + i] !== got[j]) bad++;
        end
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < 16; i++) if (samp[sp + i] !== ((^exp) ^ parity_odd)) bad++;
        sp = sp + 16;
`endif
        for (int i = 0; i < 16; i++) if (samp[sp + i] !== 1'b1) bad++;
        chk({tag, "_data"}, 32'(got), 32'(exp));
        chk({tag, "_shape"}, 32'(bad), 32'd0);
    endtask

    // Wait for k s_ticks counted from the cycle after acceptance.
    task automatic wait_ticks(input int k);
        int seen, ci;
        seen = 0; ci = 0;
        while (seen < k && ci < k * 4 + 50) begin
            @(negedge clk);
            ci++;
            if (s_tick) seen++;
        end
        if (seen < k) chk("wait_ticks_timeout", 32'(seen), 32'(k));
    endtask

    initial begin
        int bad, changes;
        logic v0;
        reset = 1'b1; tx_start = 1'b0; din = 8'h00; tick_en = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done_tick), 32'd0);
        reset = 1'b0;

        // Single frame 0xA5.
        start_tx(8'hA5);
        capture(FRAME_TICKS);
        check_frame("a5", 0, 8'hA5);
        chk("a5_done_lat", 32'(done_at), 32'(last_tick_at + 1));
        chk("a5_done_cnt", 32'(done_cnt), 32'd1);
        chk("a5_busy_len", 32'(busy_clks >= FRAME_TICKS * 4 - 4 && busy_clks <= FRAME_TICKS * 4 + 4), 32'd1);

        // A request during a frame is dropped.
        start_tx(8'h00);
        fork
            capture(FRAME_TICKS);
            begin
                repeat (200) @(posedge clk);
                #1; din = 8'hFF; tx_start = 1'b1;
                @(posedge clk); #1; tx_start = 1'b0;
            end
        join
        check_frame("ign", 0, 8'h00);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || tx !== 1'b1 || tx_done_tick !== 1'b0) bad++;
        end
        chk("ign_no_second", 32'(bad), 32'd0);

        // Back-to-back frames: the second request comes in the done cycle.
        start_tx(8'h55);
        fork
            capture(2 * FRAME_TICKS);
            begin
                int ci;
                ci = 0;
                do begin @(negedge clk); ci++; end while (!tx_done_tick && ci < 2000);
                din = 8'h3C; tx_start = 1'b1;
                @(posedge clk); #1; tx_start = 1'b0;
            end
        join
        check_frame("b2b1", 0, 8'h55);
        check_frame("b2b2", FRAME_TICKS, 8'h3C);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
        chk("b2b_gap", 32'(fall_at), 32'(done_at + 1));

        // Stall inside data bit 2 (ticks 49..64).
        start_tx(8'h04);
        fork
            capture(FRAME_TICKS);
            begin
                wait_ticks(53);
                tick_en = 1'b0;
                v0 = tx; changes = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (tx !== v0) changes++;
                end
                chk("stall_level", 32'(v0), 32'd1);
                chk("stall_frozen", 32'(changes), 32'd0);
                tick_en = 1'b1;
            end
        join
        check_frame("stall", 0, 8'h04);

        // Reset during data bit 3 (ticks 65..80) while the line is low.
        start_tx(8'h00);
        wait_ticks(69);
        chk("mrst_pre_tx", 32'(tx), 32'd0);
        reset = 1'b1;
        #1;
        chk("mrst_tx", 32'(tx), 32'd1);
        chk("mrst_busy", 32'(tx_busy), 32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || tx !== 1'b1 || tx_done_tick !== 1'b0) bad++;
        end
        chk("mrst_quiet", 32'(bad), 32'd0);
        start_tx(8'hC3);
        capture(FRAME_TICKS);
        check_frame("mrst_next", 0, 8'hC3);
        chk("mrst_next_done", 32'(done_cnt), 32'd1);

`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
        start_tx(8'h07);
        capture(FRAME_TICKS);
        check_frame("par_even", 0, 8'h07);
        chk("par_even_bit", 32'(samp[144]), 32'd1);
        chk("par_even_done", 32'(done_at), 32'(last_tick_at + 1));
        parity_odd = 1'b1;
        start_tx(8'h07);
        parity_odd = 1'b0;
        capture(FRAME_TICKS);
        parity_odd = 1'b1;
        check_frame("par_odd", 0, 8'h07);
        chk("par_odd_bit", 32'(samp[144]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
